// File: rtl/helm_msg_rcv_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : helm_msg_rcv_gen_if
// Description : Byte-in / message-out bundle of the helm message receiver.
//               slave  : receiver side (takes rx bytes, drives msg_* and busy)
//               master : byte source / message consumer side
//               rx_vld, rx_data           : received byte strobe and value
//               msg_type .. msg_data_length : header fields as last captured
//               msg_data_wr/adr/data      : payload byte stream
//               msg_exec, msg_chksum_err, msg_len_err, msg_timeout : frame end
//               msg_dup                   : repeat qualifier for msg_exec
//               busy                      : receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
interface helm_msg_rcv_gen_if;
    logic       rx_vld;
    logic [7:0] rx_data;
    logic [7:0] msg_type;
    logic [7:0] msg_seq_no;
    logic [7:0] msg_page;
    logic [7:0] msg_offset;
    logic [7:0] msg_data_length;
    logic       msg_data_wr;
    logic [7:0] msg_data_adr;
    logic [7:0] msg_data;
    logic       msg_exec;
    logic       msg_chksum_err;
    logic       msg_len_err;
    logic       msg_timeout;
    logic       msg_dup;
    logic       busy;

    modport slave (
        input  rx_vld, rx_data,
        output msg_type, msg_seq_no, msg_page, msg_offset, msg_data_length,
               msg_data_wr, msg_data_adr, msg_data,
               msg_exec, msg_chksum_err, msg_len_err, msg_timeout, msg_dup, busy
    );

    modport master (
        output rx_vld, rx_data,
        input  msg_type, msg_seq_no, msg_page, msg_offset, msg_data_length,
               msg_data_wr, msg_data_adr, msg_data,
               msg_exec, msg_chksum_err, msg_len_err, msg_timeout, msg_dup, busy
    );
endinterface
`default_nettype wire

// File: rtl/helm_msg_rcv_gen.sv
`default_nettype none
// ============================================================================
// Module      : helm_msg_rcv_gen
// Description : UART message receiver. Hunts a sliding preamble window, parses
//               the 5-byte header, streams payload bytes with their index,
//               verifies a sum/XOR checksum and flags inter-byte timeout,
//               over-length frames and repeated sequence numbers.
//               clk : system clock
//               rst : asynchronous active-high reset
//               bus : helm_msg_rcv_gen_if.slave (rx byte in, msg_* out)
// Revision    : 1.0 - initial release
// ============================================================================
module helm_msg_rcv_gen #(
    parameter logic [31:0] PREAMBLE    = 32'hAA995566,
    parameter int          PRE_BYTES   = 4,
    parameter int          MAX_LEN     = 16,
    parameter int          CHK_MODE    = 0,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    helm_msg_rcv_gen_if.slave   bus
);
    localparam int              c_PW      = 8 * PRE_BYTES;
    localparam logic [c_PW-1:0] c_PRE     = PREAMBLE[c_PW-1:0];
    localparam int              c_TW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST = (TIMEOUT_CYC > 0) ? c_TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [7:0]      c_MAX_LEN = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CHK  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_PW-1:0] r_window, w_win_shift;
    logic [2:0]      r_hdr_cnt;
    logic [7:0]      r_idx, r_len, r_acc, w_acc_nxt;
    logic [c_TW-1:0] r_timer;
    logic [7:0]      r_last_seq;
    logic            r_last_valid;
    logic            w_timeout, w_pre_hit, w_len_err, w_chk_ok, w_chk_bad;

    logic [7:0] r_type, r_seq, r_page, r_offset, r_dlen, r_adr, r_data;
    logic       r_wr, r_exec, r_chk_err, r_len_err, r_to, r_dup, r_busy;

    // Oldest preamble byte sits in the top of the window.
    if (PRE_BYTES == 1) begin : g_win_one
        assign w_win_shift = bus.rx_data;
    end else begin : g_win_multi
        assign w_win_shift = {r_window[c_PW-9:0], bus.rx_data};
    end

    assign w_acc_nxt = (CHK_MODE == 1) ? (r_acc ^ bus.rx_data) : (r_acc + bus.rx_data);

    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_state != HUNT) && !bus.rx_vld &&
                       (r_timer == c_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HUNT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_hit   = 1'b0;
        w_len_err   = 1'b0;
        w_chk_ok    = 1'b0;
        w_chk_bad   = 1'b0;
        case (r_state)
            HUNT: if (bus.rx_vld && (w_win_shift == c_PRE)) begin
                w_pre_hit   = 1'b1;
                w_state_nxt = HDR;
            end
            HDR: if (bus.rx_vld && (r_hdr_cnt == 3'd4)) begin
                if (bus.rx_data > c_MAX_LEN) begin
                    w_len_err   = 1'b1;
                    w_state_nxt = HUNT;
                end else if (bus.rx_data == 8'd0) begin
                    w_state_nxt = CHK;
                end else begin
                    w_state_nxt = PAY;
                end
            end
            PAY: if (bus.rx_vld && (r_idx == r_len - 8'd1)) w_state_nxt = CHK;
            CHK: if (bus.rx_vld) begin
                if (bus.rx_data == r_acc) w_chk_ok  = 1'b1;
                else                      w_chk_bad = 1'b1;
                w_state_nxt = HUNT;
            end
            default: w_state_nxt = HUNT;
        endcase
        if (w_timeout) w_state_nxt = HUNT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window     <= '0;
            r_hdr_cnt    <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_acc        <= '0;
            r_timer      <= '0;
            r_last_seq   <= '0;
            r_last_valid <= 1'b0;
            r_type       <= '0;
            r_seq        <= '0;
            r_page       <= '0;
            r_offset     <= '0;
            r_dlen       <= '0;
            r_adr        <= '0;
            r_data       <= '0;
            r_wr         <= 1'b0;
            r_exec       <= 1'b0;
            r_chk_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_to         <= 1'b0;
            r_dup        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wr      <= 1'b0;
            r_exec    <= 1'b0;
            r_chk_err <= 1'b0;
            r_len_err <= w_len_err;
            r_to      <= w_timeout;
            r_dup     <= 1'b0;
            r_busy    <= (w_state_nxt != HUNT);

            if (bus.rx_vld || (r_state == HUNT) || w_timeout || (TIMEOUT_CYC == 0))
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;

            if (w_timeout) r_window <= '0;

            if (bus.rx_vld) begin
                case (r_state)
                    HUNT: begin
                        r_window <= w_win_shift;
                        if (w_pre_hit) begin
                            r_acc     <= '0;
                            r_hdr_cnt <= '0;
                        end
                    end
                    HDR: begin
                        r_acc     <= w_acc_nxt;
                        r_hdr_cnt <= r_hdr_cnt + 3'd1;
                        case (r_hdr_cnt)
                            3'd0:    r_type   <= bus.rx_data;
                            3'd1:    r_seq    <= bus.rx_data;
                            3'd2:    r_page   <= bus.rx_data;
                            3'd3:    r_offset <= bus.rx_data;
                            default: begin
                                r_dlen <= bus.rx_data;
                                r_len  <= bus.rx_data;
                                r_idx  <= '0;
                            end
                        endcase
                    end
                    PAY: begin
                        r_acc  <= w_acc_nxt;
                        r_wr   <= 1'b1;
                        r_adr  <= r_idx;
                        r_data <= bus.rx_data;
                        r_idx  <= r_idx + 8'd1;
                    end
                    default: begin
                        r_window <= '0;
                        if (w_chk_ok) begin
                            r_exec       <= 1'b1;
                            r_dup        <= r_last_valid && (r_seq == r_last_seq);
                            r_last_seq   <= r_seq;
                            r_last_valid <= 1'b1;
                        end
                        r_chk_err <= w_chk_bad;
                    end
                endcase
            end
        end
    end

    assign bus.msg_type        = r_type;
    assign bus.msg_seq_no      = r_seq;
    assign bus.msg_page        = r_page;
    assign bus.msg_offset      = r_offset;
    assign bus.msg_data_length = r_dlen;
    assign bus.msg_data_wr     = r_wr;
    assign bus.msg_data_adr    = r_adr;
    assign bus.msg_data        = r_data;
    assign bus.msg_exec        = r_exec;
    assign bus.msg_chksum_err  = r_chk_err;
    assign bus.msg_len_err     = r_len_err;
    assign bus.msg_timeout     = r_to;
    assign bus.msg_dup         = r_dup;
    assign bus.busy            = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_helm_msg_rcv_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_helm_msg_rcv_gen
// Description : Directed self-checking bench. Instance A: 4-byte preamble,
//               sum checksum, MAX_LEN 16, 100-cycle timeout. Instance B:
//               2-byte preamble, XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_helm_msg_rcv_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    helm_msg_rcv_gen_if ifa ();
    helm_msg_rcv_gen_if ifb ();

    helm_msg_rcv_gen #(
        .PREAMBLE(32'hAA995566), .PRE_BYTES(4), .MAX_LEN(16), .CHK_MODE(0), .TIMEOUT_CYC(100)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    helm_msg_rcv_gen #(
        .PREAMBLE(32'hAA995566), .PRE_BYTES(2), .MAX_LEN(16), .CHK_MODE(1), .TIMEOUT_CYC(100)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    wire [62:0] w_outs_a = {ifa.msg_type, ifa.msg_seq_no, ifa.msg_page, ifa.msg_offset,
                            ifa.msg_data_length, ifa.msg_data_adr, ifa.msg_data,
                            ifa.msg_data_wr, ifa.msg_exec, ifa.msg_chksum_err,
                            ifa.msg_len_err, ifa.msg_timeout, ifa.msg_dup, ifa.busy};
    wire [62:0] w_outs_b = {ifb.msg_type, ifb.msg_seq_no, ifb.msg_page, ifb.msg_offset,
                            ifb.msg_data_length, ifb.msg_data_adr, ifb.msg_data,
                            ifb.msg_data_wr, ifb.msg_exec, ifb.msg_chksum_err,
                            ifb.msg_len_err, ifb.msg_timeout, ifb.msg_dup, ifb.busy};

    // One byte per call; consecutive calls give rx_vld on every clock edge.
    // Returns 1 time unit after the sampling edge, when outputs are settled.
    task automatic put(input int sel, input logic [7:0] b);
        @(negedge clk);
        if (sel == 0) begin ifa.rx_vld = 1'b1; ifa.rx_data = b; end
        else          begin ifb.rx_vld = 1'b1; ifb.rx_data = b; end
        @(posedge clk);
        #1;
        ifa.rx_vld = 1'b0;
        ifb.rx_vld = 1'b0;
    endtask

    // Frame on instance A: AA 99 55 66 | 00 seq 01 10 02 | 3C 5A | chk
    task automatic frame_a(input logic [7:0] seq, input logic [7:0] chk,
                           input logic exp_ok, input logic exp_dup);
        put(0, 8'hAA); put(0, 8'h99); put(0, 8'h55); put(0, 8'h66);
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_preamble: got %b expected 1", ifa.busy);
        end
        put(0, 8'h00); put(0, seq); put(0, 8'h01); put(0, 8'h10); put(0, 8'h02);
        checks++;
        if ({ifa.msg_type, ifa.msg_seq_no, ifa.msg_page, ifa.msg_offset, ifa.msg_data_length}
            !== {8'h00, seq, 8'h01, 8'h10, 8'h02}) begin
            errors++;
            $display("FAIL header: got %h %h %h %h %h expected 00 %h 01 10 02",
                     ifa.msg_type, ifa.msg_seq_no, ifa.msg_page, ifa.msg_offset,
                     ifa.msg_data_length, seq);
        end
        put(0, 8'h3C);
        checks++;
        if ({ifa.msg_data_wr, ifa.msg_data_adr, ifa.msg_data} !== {1'b1, 8'h00, 8'h3C}) begin
            errors++; $display("FAIL payload0: got wr=%b adr=%h data=%h expected 1 00 3c",
                               ifa.msg_data_wr, ifa.msg_data_adr, ifa.msg_data);
        end
        put(0, 8'h5A);
        checks++;
        if ({ifa.msg_data_wr, ifa.msg_data_adr, ifa.msg_data} !== {1'b1, 8'h01, 8'h5A}) begin
            errors++; $display("FAIL payload1: got wr=%b adr=%h data=%h expected 1 01 5a",
                               ifa.msg_data_wr, ifa.msg_data_adr, ifa.msg_data);
        end
        put(0, chk);
        checks++;
        if ({ifa.msg_exec, ifa.msg_chksum_err, ifa.msg_dup, ifa.busy, ifa.msg_data_wr,
             ifa.msg_len_err, ifa.msg_timeout}
            !== {exp_ok, ~exp_ok, exp_dup, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL frame_end: got exec=%b cerr=%b dup=%b busy=%b wr=%b lerr=%b to=%b expected exec=%b cerr=%b dup=%b 0 0 0 0",
                     ifa.msg_exec, ifa.msg_chksum_err, ifa.msg_dup, ifa.busy, ifa.msg_data_wr,
                     ifa.msg_len_err, ifa.msg_timeout, exp_ok, ~exp_ok, exp_dup);
        end
    endtask

    task automatic test_reset();
        ifa.rx_vld = 1'b0; ifa.rx_data = 8'h00;
        ifb.rx_vld = 1'b0; ifb.rx_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (w_outs_a !== 63'd0) begin
            errors++; $display("FAIL reset_a: got %h expected 0", w_outs_a);
        end
        checks++;
        if (w_outs_b !== 63'd0) begin
            errors++; $display("FAIL reset_b: got %h expected 0", w_outs_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sum of 00 07 01 10 02 3C 5A is B0.
    task automatic test_basic();
        frame_a(8'h07, 8'hB0, 1'b1, 1'b0);
    endtask

    // Repeat seq 07 back to back, then a corrupted checksum.
    task automatic test_back_to_back();
        frame_a(8'h07, 8'hB0, 1'b1, 1'b1);
        frame_a(8'h07, 8'hB1, 1'b0, 1'b0);
    endtask

    task automatic test_len_err();
        put(0, 8'hAA); put(0, 8'h99); put(0, 8'h55); put(0, 8'h66);
        put(0, 8'h00); put(0, 8'h08); put(0, 8'h01); put(0, 8'h10);
        put(0, 8'h11);
        checks++;
        if ({ifa.msg_len_err, ifa.msg_data_wr, ifa.busy, ifa.msg_exec, ifa.msg_data_length}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h11}) begin
            errors++; $display("FAIL len_err: got lerr=%b wr=%b busy=%b exec=%b len=%h expected 1 0 0 0 11",
                               ifa.msg_len_err, ifa.msg_data_wr, ifa.busy, ifa.msg_exec,
                               ifa.msg_data_length);
        end
        put(0, 8'h3C);
        checks++;
        if ({ifa.msg_data_wr, ifa.msg_len_err, ifa.busy} !== 3'b000) begin
            errors++; $display("FAIL len_err_discard: got wr=%b lerr=%b busy=%b expected 0 0 0",
                               ifa.msg_data_wr, ifa.msg_len_err, ifa.busy);
        end
        // Sum of 00 09 01 10 02 3C 5A is B2.
        frame_a(8'h09, 8'hB2, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        put(0, 8'hAA); put(0, 8'h99); put(0, 8'h55); put(0, 8'h66);
        put(0, 8'h00); put(0, 8'h0A); put(0, 8'h01);
        for (int i = 1; i < 100; i++) begin
            @(posedge clk); #1;
            if (ifa.msg_timeout !== 1'b0 || ifa.busy !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early: got %0d bad cycles expected 0", early);
        end
        @(posedge clk); #1;
        checks++;
        if ({ifa.msg_timeout, ifa.busy, ifa.msg_exec, ifa.msg_chksum_err, ifa.msg_len_err}
            !== 5'b10000) begin
            errors++; $display("FAIL timeout_pulse: got to=%b busy=%b exec=%b cerr=%b lerr=%b expected 1 0 0 0 0",
                               ifa.msg_timeout, ifa.busy, ifa.msg_exec, ifa.msg_chksum_err,
                               ifa.msg_len_err);
        end
        @(posedge clk); #1;
        checks++;
        if ({ifa.msg_timeout, ifa.msg_seq_no, ifa.msg_page} !== {1'b0, 8'h0A, 8'h01}) begin
            errors++; $display("FAIL timeout_hold: got to=%b seq=%h page=%h expected 0 0a 01",
                               ifa.msg_timeout, ifa.msg_seq_no, ifa.msg_page);
        end
        repeat (2) @(posedge clk);
        // Sum of 00 0A 01 10 02 3C 5A is B3.
        frame_a(8'h0A, 8'hB3, 1'b1, 1'b0);
    endtask

    // 55 55 66 overlaps the 2-byte preamble 5566; XOR of 02 01 00 00 00 is 03.
    task automatic test_overlap();
        put(1, 8'h55); put(1, 8'h55);
        checks++;
        if (ifb.busy !== 1'b0) begin
            errors++; $display("FAIL overlap_early: got busy=%b expected 0", ifb.busy);
        end
        put(1, 8'h66);
        checks++;
        if (ifb.busy !== 1'b1) begin
            errors++; $display("FAIL overlap_hit: got busy=%b expected 1", ifb.busy);
        end
        put(1, 8'h02); put(1, 8'h01); put(1, 8'h00); put(1, 8'h00); put(1, 8'h00);
        put(1, 8'h03);
        checks++;
        if ({ifb.msg_exec, ifb.msg_chksum_err, ifb.msg_dup, ifb.busy, ifb.msg_type,
             ifb.msg_seq_no, ifb.msg_data_length}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h01, 8'h00}) begin
            errors++; $display("FAIL overlap_exec: got exec=%b cerr=%b dup=%b busy=%b type=%h seq=%h len=%h expected 1 0 0 0 02 01 00",
                               ifb.msg_exec, ifb.msg_chksum_err, ifb.msg_dup, ifb.busy,
                               ifb.msg_type, ifb.msg_seq_no, ifb.msg_data_length);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        put(0, 8'hAA); put(0, 8'h99); put(0, 8'h55); put(0, 8'h66);
        put(0, 8'h00); put(0, 8'h07); put(0, 8'h01); put(0, 8'h10); put(0, 8'h02);
        put(0, 8'h3C);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (w_outs_a !== 63'd0) begin
            errors++; $display("FAIL reset_mid: got %h expected 0", w_outs_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (w_outs_a !== 63'd0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL reset_quiet: got %0d non-zero cycles expected 0", pulses);
        end
        // Last executed seq is forgotten, so seq 07 is not a repeat.
        frame_a(8'h07, 8'hB0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_len_err();
        test_timeout();
        test_overlap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
